// File: rtl/draw_controller.sv
// draw_controller
// Sequences the lottery draw over the rolling-code digits. A start pulse sets
// every digit rolling. A stop pulse then freezes the digits one at a time,
// most-significant first, STOP_GAP clk cycles apart. After one more STOP_GAP
// of settle time the synchronised code is latched into result and done rises.
//
// Interface semantics: start and stop are single-cycle pulses sampled on the
// rising edge of clk. There is no backpressure: a pulse that the current state
// does not act on is dropped. result is valid whenever done is high, and it
// holds the last captured draw until the next capture or a reset.
module draw_controller #(
    parameter int DIGITS   = 7,
    parameter int STOP_GAP = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [4*DIGITS-1:0]   code_in,
    output logic [DIGITS-1:0]     flag,
    output logic [4*DIGITS-1:0]   result,
    output logic                  done,
    output logic                  busy,
    output logic [2:0]            state
);

    localparam int CW = $clog2(STOP_GAP + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] GAP_LAST  = CW'(STOP_GAP - 1);
    localparam logic [IW-1:0] IDX_START = (DIGITS > 1) ? IW'(DIGITS - 2) : '0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STOPPING = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DIGITS-1:0]     flag_q, flag_d;
    logic [4*DIGITS-1:0]   result_q, result_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   code_s1, code_s;

    // Two-stage synchroniser for the live digit codes; captures only use code_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_s1 <= '0;
            code_s  <= '0;
        end else begin
            code_s1 <= code_in;
            code_s  <= code_s1;
        end
    end

    // State and datapath registers; reset aborts any draw and clears the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            flag_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state logic: roll, staggered freeze, settle, then capture.
    always_comb begin
        state_d  = state_q;
        flag_d   = flag_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    flag_d  = '1;
                end
            end

            ST_RUN: begin
                flag_d = '1;
                // stop beats a simultaneous start here
                if (stop) begin
                    cnt_d = '0;
                    if (DIGITS == 1) begin
                        state_d = ST_SETTLE;
                        flag_d  = '0;
                    end else begin
                        state_d            = ST_STOPPING;
                        flag_d[DIGITS-1]   = 1'b0;
                        idx_d              = IDX_START;
                    end
                end
            end

            ST_STOPPING: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d         = '0;
                    flag_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_SETTLE: begin
                flag_d = '0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d    = '0;
                    result_d = code_s;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                flag_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                    flag_d  = '1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                flag_d  = '0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign flag   = flag_q;
    assign result = result_q;
    assign state  = state_q;
    assign done   = (state_q == ST_DONE);
    assign busy   = (state_q == ST_RUN) || (state_q == ST_STOPPING) ||
                    (state_q == ST_SETTLE);

endmodule

// File: doc/draw_controller.md
Name: draw_controller

Overview:
- Lottery-draw sequencing controller for the 7-digit rolling-code datapath (1 Chinese-zodiac digit, 1 letter digit, 5 numeric digits; 28-bit packed code).
- Drives the per-digit `flag` enables: starts all digits rolling on `start`, then on `stop` freezes them one at a time, most-significant first, at fixed intervals.
- After all digits are frozen and settled, latches the final 28-bit result and raises `done` for the display/announcer logic.

Parameters:
- DIGITS, 7, number of digit sequencers controlled (one flag bit and one 4-bit code slice each).
- STOP_GAP, 25000000, clk cycles between successive digit freezes, and the settle time before capture; must be ≥ 1 and longer than the slowest digit clock period plus 3 clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse, synchronous to clk; begin a draw
- stop  input  1  single-cycle pulse, synchronous to clk; begin sequential freeze
- code_in  input  4*DIGITS  live packed digit codes; digit k at [4k+3:4k], digit DIGITS-1 leftmost
- flag  output  DIGITS  per-digit roll enable to sequencers; 1 = rolling
- result  output  4*DIGITS  latched final draw code
- done  output  1  high while a valid result is held and no draw is active
- busy  output  1  high in RUN, STOPPING, SETTLE
- state  output  3  current FSM state encoding (debug)

Behaviour:
- Reset (async, immediate):
  - state = IDLE (0), flag = 0, result = 0, done = 0, busy = 0.
  - gap counter = 0, digit index = 0, sync registers = 0.
- code_in passes through a 2-stage synchronizer (code_s). Every result capture uses code_s, never raw code_in.
- FSM encoding: IDLE = 0, RUN = 1, STOPPING = 2, SETTLE = 3, DONE = 4.
- IDLE:
  - start → RUN; on that edge flag = all ones, busy = 1.
  - stop alone is ignored.
- RUN:
  - flag stays all ones.
  - start is ignored.
  - stop → STOPPING; on that edge flag[DIGITS-1] = 0, index = DIGITS-2, gap counter = 0.
- STOPPING:
  - Gap counter increments every cycle.
  - When the counter reaches STOP_GAP-1: flag[index] = 0 and the counter clears.
    - If index = 0 → SETTLE.
    - Otherwise index decrements.
  - Digit k is frozen (DIGITS-1-k)*STOP_GAP cycles after the stop edge.
  - Digit 0 is frozen (DIGITS-1)*STOP_GAP cycles after the stop edge.
  - start and stop are ignored.
- SETTLE:
  - flag = 0.
  - Counter runs STOP_GAP cycles. On the final edge: result = code_s, done = 1, busy = 0, → DONE.
- DONE:
  - result held, done = 1.
  - start → RUN; on that edge done = 0 and flag = all ones.
  - result keeps the previous draw until the next SETTLE capture.
  - stop is ignored.
- Simultaneous start & stop:
  - In IDLE and DONE, start wins.
  - In RUN, stop wins.
  - Elsewhere, both are ignored.
- Flags never re-assert during STOPPING or SETTLE, and a frozen digit is never unfrozen before DONE.
- Reset during any state aborts immediately: all flags drop and result clears to 0.
- Counter width is $clog2(STOP_GAP+1); no overflow is possible.
- DIGITS = 1: stop goes straight to SETTLE, with flag[0] cleared on the stop edge.

Test Plan (STOP_GAP = 4, DIGITS = 7, code_in driven by the bench):
- Reset then idle: rst pulse → state=0, flag=0, result=0, done=0, busy=0; a stop pulse leaves all unchanged.
- Normal draw: start at cycle 0 → flag=7'h7F, busy=1 from cycle 1.
  - stop at cycle 10 → flag=7'h3F after edge 10, then 7'h1F at 14, 7'h0F at 18, …, 7'h00 at 34.
  - SETTLE with code_in=28'h3A12345 → result=28'h3A12345, done=1 at edge 38, busy=0.
- Ignored pulses: start during RUN leaves flags 7'h7F; start/stop during STOPPING do not alter the freeze timing above.
- Re-draw: from DONE, start → done=0, flag=7'h7F, result still 28'h3A12345; the next draw with code_in=28'h0F99999 yields result=28'h0F99999.
- Simultaneous start+stop: in IDLE → RUN; in RUN → STOPPING with flag=7'h3F.
- Reset mid-STOPPING: assert rst asynchronously between clk edges when flag=7'h0F → flag=0, state=0, result=0 immediately; after release, a start begins a fresh draw.
